// File: rtl/prach_ditfft3_bf1_inv.sv
// -----------------------------------------------------------------------------
// prach_ditfft3_bf1_inv
//
// Inverse of the radix-3 DIT stage-1 butterfly on the PRACH long-sequence path.
// It collects an input triple (y0, y1, y2) = (x0, x1+x2, x2-x1) from a
// valid-gated stream and emits the reconstructed triple (x0, x1, x2) as three
// back-to-back output cycles:
//   x0 = y0
//   x1 = (y1 - y2) / 2
//   x2 = (y1 + y2) / 2
// Halving is an arithmetic shift (ROUND=0, floor) or add-one-then-shift
// (ROUND=1, round half up). Real and imaginary parts are independent.
//
// Parameters
//   ROUND : 0 = floor halving, 1 = round-half-up halving
//   W     : signed sample component width
//
// Ports
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   din_dr    in   input real part (signed, W bits)
//   din_di    in   input imaginary part (signed, W bits)
//   din_dv    in   input sample valid
//   sync_in   in   marks y0 of a triple; only looked at when din_dv=1
//   dout_dr   out  output real part (holds its value while idle)
//   dout_di   out  output imaginary part (holds its value while idle)
//   dout_dv   out  output valid, high for three gap-free cycles per triple
//   sync_out  out  high with x0 of each output triple
//   frame_err out  one-cycle pulse the cycle after a partial triple is aborted
//
// Handshake: a sample is taken on a rising edge where din_dv=1; there is no
// ready/backpressure, and the source must space triple completions at least
// three cycles apart so that output triples never overlap.
// -----------------------------------------------------------------------------
module prach_ditfft3_bf1_inv #(
    parameter int ROUND = 1,
    parameter int W     = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din_dr,
    input  logic [W-1:0] din_di,
    input  logic         din_dv,
    input  logic         sync_in,
    output logic [W-1:0] dout_dr,
    output logic [W-1:0] dout_di,
    output logic         dout_dv,
    output logic         sync_out,
    output logic         frame_err
);

    // Rounding constant added before the halving shift.
    localparam logic [W+1:0] RND = (ROUND != 0) ? (W+2)'(1) : '0;

    // -------------------------------------------------------------------------
    // Input FSM: gathers y0, y1, y2. Advances only on valid cycles.
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GOT0 = 2'd1,
        GOT1 = 2'd2
    } in_state_t;

    in_state_t state;
    in_state_t state_nxt;

    logic cap_y0;    // take the current sample as y0
    logic cap_y1;    // take the current sample as y1
    logic tri_done;  // current sample is y2: triple complete
    logic abort;     // sync arrived while a partial triple was open

    always_comb begin
        state_nxt = state;
        cap_y0    = 1'b0;
        cap_y1    = 1'b0;
        tri_done  = 1'b0;
        abort     = 1'b0;
        if (din_dv) begin
            case (state)
                IDLE: begin
                    // Samples without sync while idle are silently dropped.
                    if (sync_in) begin
                        cap_y0    = 1'b1;
                        state_nxt = GOT0;
                    end
                end
                GOT0: begin
                    if (sync_in) begin
                        abort     = 1'b1;
                        cap_y0    = 1'b1;
                        state_nxt = GOT0;
                    end else begin
                        cap_y1    = 1'b1;
                        state_nxt = GOT1;
                    end
                end
                GOT1: begin
                    if (sync_in) begin
                        abort     = 1'b1;
                        cap_y0    = 1'b1;
                        state_nxt = GOT0;
                    end else begin
                        tri_done  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Captured y0 / y1. y2 is never stored: it is consumed straight from the
    // input on the completing cycle.
    // -------------------------------------------------------------------------
    logic [W-1:0] y0_r;
    logic [W-1:0] y0_i;
    logic [W-1:0] y1_r;
    logic [W-1:0] y1_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y0_r <= '0;
            y0_i <= '0;
            y1_r <= '0;
            y1_i <= '0;
        end else begin
            if (cap_y0) begin
                y0_r <= din_dr;
                y0_i <= din_di;
            end
            if (cap_y1) begin
                y1_r <= din_dr;
                y1_i <= din_di;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Arithmetic: sign-extend to W+2 bits, form sum/difference, halve.
    // -------------------------------------------------------------------------
    function automatic logic [W+1:0] sext(input logic [W-1:0] v);
        return {{2{v[W-1]}}, v};
    endfunction

    // Arithmetic shift right by one followed by truncation to W bits is just
    // bits [W:1] of the W+2-bit value, independent of its sign.
    function automatic logic [W-1:0] halve(input logic [W+1:0] v);
        logic [W+1:0] t;
        t = v + RND;
        return t[W:1];
    endfunction

    logic [W+1:0] y1r_x;
    logic [W+1:0] y1i_x;
    logic [W+1:0] y2r_x;
    logic [W+1:0] y2i_x;
    logic [W-1:0] x1_r;
    logic [W-1:0] x1_i;
    logic [W-1:0] x2_r;
    logic [W-1:0] x2_i;

    always_comb begin
        y1r_x = sext(y1_r);
        y1i_x = sext(y1_i);
        y2r_x = sext(din_dr);
        y2i_x = sext(din_di);
        x1_r  = halve(y1r_x - y2r_x);
        x1_i  = halve(y1i_x - y2i_x);
        x2_r  = halve(y1r_x + y2r_x);
        x2_i  = halve(y1i_x + y2i_x);
    end

    // -------------------------------------------------------------------------
    // Output stage. x0 goes straight to the output register on the completing
    // edge; x1 and x2 wait in pend1/pend2 and follow on the next two edges.
    // out_cnt counts the samples still waiting (2, 1, 0).
    // -------------------------------------------------------------------------
    logic [W-1:0] pend1_r;
    logic [W-1:0] pend1_i;
    logic [W-1:0] pend2_r;
    logic [W-1:0] pend2_i;
    logic [1:0]   out_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_dr  <= '0;
            dout_di  <= '0;
            dout_dv  <= 1'b0;
            sync_out <= 1'b0;
            pend1_r  <= '0;
            pend1_i  <= '0;
            pend2_r  <= '0;
            pend2_i  <= '0;
            out_cnt  <= 2'd0;
        end else if (tri_done) begin
            dout_dr  <= y0_r;
            dout_di  <= y0_i;
            dout_dv  <= 1'b1;
            sync_out <= 1'b1;
            pend1_r  <= x1_r;
            pend1_i  <= x1_i;
            pend2_r  <= x2_r;
            pend2_i  <= x2_i;
            out_cnt  <= 2'd2;
        end else if (out_cnt == 2'd2) begin
            dout_dr  <= pend1_r;
            dout_di  <= pend1_i;
            dout_dv  <= 1'b1;
            sync_out <= 1'b0;
            out_cnt  <= 2'd1;
        end else if (out_cnt == 2'd1) begin
            dout_dr  <= pend2_r;
            dout_di  <= pend2_i;
            dout_dv  <= 1'b1;
            sync_out <= 1'b0;
            out_cnt  <= 2'd0;
        end else begin
            // Idle: data outputs keep their last value.
            dout_dv  <= 1'b0;
            sync_out <= 1'b0;
        end
    end

    // Abort pulse, registered so it appears the cycle after the offending sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= abort;
        end
    end

endmodule

// File: tb/tb_prach_ditfft3_bf1_inv.sv
// -----------------------------------------------------------------------------
// tb_prach_ditfft3_bf1_inv
//
// Drives one shared input stream into two instances of the inverse stage
// (ROUND=0 and ROUND=1). A reference model of the input framing predicts every
// output sample (with its exact cycle) and every frame_err pulse; predictions
// go into expected queues and are popped by a negedge monitor.
// -----------------------------------------------------------------------------
module tb_prach_ditfft3_bf1_inv;

    localparam int W  = 18;
    localparam int EW = 33 + 2 * W;  // {cycle[31:0], sync, re[W-1:0], im[W-1:0]}

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- DUTs
    logic [W-1:0] din_dr = '0;
    logic [W-1:0] din_di = '0;
    logic         din_dv = 1'b0;
    logic         sync_in = 1'b0;

    logic [W-1:0] dr0, di0, dr1, di1;
    logic         dv0, so0, fe0, dv1, so1, fe1;

    prach_ditfft3_bf1_inv #(.ROUND(0), .W(W)) u_r0 (
        .clk(clk), .rst_n(rst_n),
        .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv), .sync_in(sync_in),
        .dout_dr(dr0), .dout_di(di0), .dout_dv(dv0), .sync_out(so0), .frame_err(fe0)
    );

    prach_ditfft3_bf1_inv #(.ROUND(1), .W(W)) u_r1 (
        .clk(clk), .rst_n(rst_n),
        .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv), .sync_in(sync_in),
        .dout_dr(dr1), .dout_di(di1), .dout_dv(dv1), .sync_out(so1), .frame_err(fe1)
    );

    // ---------------------------------------------------------------- checking
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- scoreboard
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    int            err_q[$];

    // Override of expected x1/x2 per rounding mode (hand-derived constants or
    // the original round-trip values); x0 always comes from the input y0.
    logic ov_en = 1'b0;
    int   ov_x1r[2], ov_x1i[2], ov_x2r[2], ov_x2i[2];

    task automatic set_ov(input int m, input int x1r, input int x1i, input int x2r, input int x2i);
        ov_x1r[m] = x1r;
        ov_x1i[m] = x1i;
        ov_x2r[m] = x2r;
        ov_x2i[m] = x2i;
    endtask

    function automatic logic [EW-1:0] mk(input int c, input logic s, input int r, input int i);
        return {32'(c), s, W'(r), W'(i)};
    endfunction

    // Halving in plain integer arithmetic, then wrap to W bits.
    function automatic int m_half(input int a, input int rnd);
        int           t;
        logic [W-1:0] tr;
        t  = (a + rnd) >>> 1;
        tr = t[W-1:0];
        return int'($signed(tr));
    endfunction

    int m_st = 0;
    int m_y0r, m_y0i, m_y1r, m_y1i;

    // Reference framing model, stepped once per accepted clock edge.
    task automatic model_step(input int r, input int i, input logic v, input logic s);
        if (v) begin
            if (s) begin
                if (m_st != 0) err_q.push_back(cyc);
                m_y0r = r;
                m_y0i = i;
                m_st  = 1;
            end else if (m_st == 1) begin
                m_y1r = r;
                m_y1i = i;
                m_st  = 2;
            end else if (m_st == 2) begin
                for (int m = 0; m < 2; m++) begin
                    int x1r, x1i, x2r, x2i;
                    if (ov_en) begin
                        x1r = ov_x1r[m]; x1i = ov_x1i[m];
                        x2r = ov_x2r[m]; x2i = ov_x2i[m];
                    end else begin
                        x1r = m_half(m_y1r - r, m); x1i = m_half(m_y1i - i, m);
                        x2r = m_half(m_y1r + r, m); x2i = m_half(m_y1i + i, m);
                    end
                    if (m == 0) begin
                        exp_q0.push_back(mk(cyc,     1'b1, m_y0r, m_y0i));
                        exp_q0.push_back(mk(cyc + 1, 1'b0, x1r, x1i));
                        exp_q0.push_back(mk(cyc + 2, 1'b0, x2r, x2i));
                    end else begin
                        exp_q1.push_back(mk(cyc,     1'b1, m_y0r, m_y0i));
                        exp_q1.push_back(mk(cyc + 1, 1'b0, x1r, x1i));
                        exp_q1.push_back(mk(cyc + 2, 1'b0, x2r, x2i));
                    end
                end
                m_st = 0;
            end
        end
    endtask

    // ---------------------------------------------------------------- driver
    // Presents one input cycle, lets the edge take it, then steps the model.
    task automatic drive(input int r, input int i, input logic v, input logic s);
        din_dr  = W'(r);
        din_di  = W'(i);
        din_dv  = v;
        sync_in = s;
        @(posedge clk);
        #1;
        model_step(r, i, v, s);
        din_dv  = 1'b0;
        sync_in = 1'b0;
    endtask

    // Invalid cycles carry random data and random sync, which must be ignored.
    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            drive(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0,
                  1'($urandom_range(0, 1)));
    endtask

    task automatic triple(input int y0r, input int y0i, input int y1r, input int y1i,
                          input int y2r, input int y2i);
        drive(y0r, y0i, 1'b1, 1'b1);
        drive(y1r, y1i, 1'b1, 1'b0);
        drive(y2r, y2i, 1'b1, 1'b0);
    endtask

    // ---------------------------------------------------------------- monitor
    task automatic mon_one(input int m, input logic dv, input logic so,
                           input logic [W-1:0] dr, input logic [W-1:0] di);
        logic [EW-1:0] e;
        logic          have;
        string         p;
        int            ec;
        p    = (m == 0) ? "r0" : "r1";
        have = 1'b0;
        e    = '0;
        if (m == 0 && exp_q0.size() > 0) begin e = exp_q0[0]; have = 1'b1; end
        if (m == 1 && exp_q1.size() > 0) begin e = exp_q1[0]; have = 1'b1; end
        ec = int'(e[EW-1 -: 32]);
        if (have && ec < cyc) begin
            check({p, "_late"}, 64'(cyc), 64'(ec));
            if (m == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
            have = 1'b0;
        end
        if (have && ec == cyc) begin
            if (m == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
            check({p, "_dv"},   64'(dv), 64'(1));
            check({p, "_sync"}, 64'(so), 64'(e[2*W]));
            check({p, "_dr"},   64'(dr), 64'(e[2*W-1 -: W]));
            check({p, "_di"},   64'(di), 64'(e[W-1:0]));
        end else begin
            check({p, "_idle_dv"},   64'(dv), 64'(0));
            check({p, "_idle_sync"}, 64'(so), 64'(0));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            logic exp_err;
            mon_one(0, dv0, so0, dr0, di0);
            mon_one(1, dv1, so1, dr1, di1);
            exp_err = (err_q.size() > 0) && (err_q[0] == cyc);
            if (exp_err) void'(err_q.pop_front());
            check("r0_frame_err", 64'(fe0), 64'(exp_err));
            check("r1_frame_err", 64'(fe1), 64'(exp_err));
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_dr0"}, 64'(dr0), 64'(0));
        check({tag, "_di0"}, 64'(di0), 64'(0));
        check({tag, "_dv0"}, 64'(dv0), 64'(0));
        check({tag, "_so0"}, 64'(so0), 64'(0));
        check({tag, "_fe0"}, 64'(fe0), 64'(0));
        check({tag, "_dr1"}, 64'(dr1), 64'(0));
        check({tag, "_di1"}, 64'(di1), 64'(0));
        check({tag, "_dv1"}, 64'(dv1), 64'(0));
        check({tag, "_so1"}, 64'(so1), 64'(0));
        check({tag, "_fe1"}, 64'(fe1), 64'(0));
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Contiguous triple with hand-derived results (same for both modes).
        ov_en = 1'b1;
        set_ov(0, 2, 3, 5, -1);
        set_ov(1, 2, 3, 5, -1);
        triple(5, 0, 7, 2, 3, -4);
        idle(4);

        // Same triple with valid gaps: y0, 2 idle, y1, 1 idle, y2.
        drive(5, 0, 1'b1, 1'b1);
        idle(2);
        drive(7, 2, 1'b1, 1'b0);
        idle(1);
        drive(3, -4, 1'b1, 1'b0);
        idle(4);

        // Rounding: y1=3, y2=0.
        set_ov(0, 1, 0, 1, 0);
        set_ov(1, 2, 0, 2, 0);
        triple(0, 0, 3, 0, 0, 0);
        idle(3);
        // Rounding: y1=-3, y2=0.
        set_ov(0, -2, 0, -2, 0);
        set_ov(1, -1, 0, -1, 0);
        triple(0, 0, -3, 0, 0, 0);
        idle(3);
        ov_en = 1'b0;

        // Extremes, checked against the integer model (including wrap).
        triple(131071, -131072, 131071, -131072, -131072, 131071);
        triple(-131072, 131071, -131072, 131071, 131071, -131072);
        triple(1, -1, 131071, 131071, 131071, 131071);
        idle(4);

        // Stray sample without sync while idle: dropped, no error.
        drive(99, 99, 1'b1, 1'b0);
        idle(2);

        // Abort from GOT1: first partial dropped, second triple delivered.
        drive(10, 1, 1'b1, 1'b1);
        drive(20, 2, 1'b1, 1'b0);
        triple(30, 3, 40, 4, 50, 5);
        idle(4);

        // Abort from GOT0 while the previous output triple is still in flight.
        triple(1, 2, 3, 4, 5, 6);
        drive(11, 12, 1'b1, 1'b1);
        drive(13, 14, 1'b1, 1'b1);
        drive(15, 16, 1'b1, 1'b0);
        drive(17, 18, 1'b1, 1'b0);
        idle(4);

        // Round trip through the forward butterfly: back-to-back, then gapped.
        ov_en = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            int x0r, x0i, x1r, x1i, x2r, x2i;
            x0r = int'($urandom_range(0, 262143)) - 131072;
            x0i = int'($urandom_range(0, 262143)) - 131072;
            x1r = int'($urandom_range(0, 131071)) - 65536;
            x1i = int'($urandom_range(0, 131071)) - 65536;
            x2r = int'($urandom_range(0, 131071)) - 65536;
            x2i = int'($urandom_range(0, 131071)) - 65536;
            set_ov(0, x1r, x1i, x2r, x2i);
            set_ov(1, x1r, x1i, x2r, x2i);
            if (f < 500) begin
                triple(x0r, x0i, x1r + x2r, x1i + x2i, x2r - x1r, x2i - x1i);
            end else begin
                drive(x0r, x0i, 1'b1, 1'b1);
                idle(int'($urandom_range(0, 2)));
                drive(x1r + x2r, x1i + x2i, 1'b1, 1'b0);
                idle(int'($urandom_range(0, 2)));
                drive(x2r - x1r, x2i - x1i, 1'b1, 1'b0);
                idle(int'($urandom_range(0, 2)));
            end
        end
        ov_en = 1'b0;
        idle(4);

        // Reset in the middle of an output triple.
        triple(100, 200, 300, 400, 500, 600);
        idle(1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        exp_q0.delete();
        exp_q1.delete();
        err_q.delete();
        m_st = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Valid sample without sync after reset: must not produce output.
        drive(7, 7, 1'b1, 1'b0);
        drive(8, 8, 1'b1, 1'b0);
        idle(6);

        check("drain_q0", 64'(exp_q0.size()), 64'(0));
        check("drain_q1", 64'(exp_q1.size()), 64'(0));
        check("drain_err", 64'(err_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
